// File: rtl/vga_pattern_gen.sv
// VGA timing generator with selectable test patterns (white, colour cycle, bars,
// checkerboard, gradient); every output is registered one clock after the counters.
module vga_pattern_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int COLOR_W         = 4,
  parameter int FRAMES_PER_STEP = 60,
  parameter int CELL_LOG2       = 5,
  parameter int GRAD_SHIFT      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         sw,
  output logic               h_sync,
  output logic               v_sync,
  output logic               onscreen,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int unsigned C_MAX = (1 << COLOR_W) - 1;

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               h_last, v_last, frame_end;
  logic [2:0]         sw_meta, sw_sync, mode, color_idx;
  logic [15:0]        frame_cnt;
  int unsigned        h_u, v_u, chk_u;
  logic [2:0]         bar_p0;
  logic               active_p0, hs_p0, vs_p0, fs_p0;
  logic [COLOR_W-1:0] r_p0, g_p0, b_p0;

  function automatic logic [3*COLOR_W-1:0] idx_color(input logic [2:0] k);
    return {{COLOR_W{k[0]}}, {COLOR_W{k[1]}}, {COLOR_W{k[2]}}};
  endfunction

  function automatic logic [COLOR_W-1:0] sat_color(input int unsigned cnt);
    int unsigned s;
    s = cnt >> GRAD_SHIFT;
    return (s > C_MAX) ? {COLOR_W{1'b1}} : s[COLOR_W-1:0];
  endfunction

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_end = h_last && v_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Mode and colour index only change on the last cycle of a frame, so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      mode      <= '0;
      frame_cnt <= '0;
      color_idx <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (frame_end) begin
        mode <= sw_sync;
        if (frame_cnt == 16'(FRAMES_PER_STEP - 1)) begin
          frame_cnt <= '0;
          color_idx <= color_idx + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  // Stage p0: pixel attributes derived combinationally from the counters.
  always_comb begin
    h_u    = 32'(h_cnt);
    v_u    = 32'(v_cnt);
    bar_p0 = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_u * 32'd8 >= 32'(i) * 32'(H_ACTIVE)) bar_p0 = bar_p0 + 3'd1;
    end
    chk_u     = (h_u >> CELL_LOG2) ^ (v_u >> CELL_LOG2);
    active_p0 = (h_u < 32'(H_ACTIVE)) && (v_u < 32'(V_ACTIVE));
    hs_p0     = !((h_u >= 32'(H_ACTIVE + H_FP)) && (h_u < 32'(H_ACTIVE + H_FP + H_SYNC)));
    vs_p0     = !((v_u >= 32'(V_ACTIVE + V_FP)) && (v_u < 32'(V_ACTIVE + V_FP + V_SYNC)));
    fs_p0     = (h_cnt == '0) && (v_cnt == '0);
    {r_p0, g_p0, b_p0} = '0;
    if (active_p0) begin
      case (mode)
        3'd1: {r_p0, g_p0, b_p0} = idx_color(color_idx);
        3'd2: {r_p0, g_p0, b_p0} = idx_color(bar_p0);
        3'd3: {r_p0, g_p0, b_p0} = {3*COLOR_W{chk_u[0]}};
        3'd4: begin
          r_p0 = sat_color(h_u);
          g_p0 = sat_color(v_u);
          b_p0 = ~r_p0;
        end
        default: {r_p0, g_p0, b_p0} = '1;
      endcase
    end
  end

  // Stage p1: registered outputs, all one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      onscreen    <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= hs_p0;
      v_sync      <= vs_p0;
      onscreen    <= active_p0;
      R           <= r_p0;
      G           <= g_p0;
      B           <= b_p0;
      frame_start <= fs_p0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced 52x37 raster: a per-cycle reference model
// plus directed literal checks of timing, pattern pixels, mode switching and reset.
module tb_vga_pattern_gen;

  localparam int HA = 40, HFP = 4, HS = 6, HBP = 2;
  localparam int VA = 30, VFP = 2, VS = 3, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int CW = 4, FPS = 2, CL = 2, GS = 1;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    sw = 3'd0;
  logic          h_sync, v_sync, onscreen, frame_start;
  logic [CW-1:0] R, G, B;

  int n = 0;
  int n_checks = 0;
  int n_fail = 0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLOR_W(CW), .FRAMES_PER_STEP(FPS), .CELL_LOG2(CL), .GRAD_SHIFT(GS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .h_sync(h_sync), .v_sync(v_sync), .onscreen(onscreen),
    .R(R), .G(G), .B(B), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Number of output cycles since reset release; output n shows raster pixel n-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: position, frame number and mode from elapsed cycles.
  int cp, cf, cx, cy, cci, ck, cr, cg, cb, cmode;
  logic e_hs, e_vs, e_on, e_fs;
  logic [15:0] act_v, exp_v;

  initial begin
    cmode = 0;
    forever begin
      @(negedge clk);
      if (n == 0) begin
        cmode = 0;
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
      end else begin
        cp  = (n - 1) % FT;
        cf  = (n - 1) / FT;
        cx  = cp % HT;
        cy  = cp / HT;
        if (cp == 0 && cf > 0) cmode = int'(sw);
        cci = (cf / FPS) % 8;
        e_on = (cx < HA) && (cy < VA);
        e_hs = !(cx >= HA + HFP && cx < HA + HFP + HS);
        e_vs = !(cy >= VA + VFP && cy < VA + VFP + VS);
        e_fs = (cx == 0) && (cy == 0);
        cr = 0; cg = 0; cb = 0;
        if (e_on) begin
          case (cmode)
            1: begin
              cr = (cci & 1) ? CMAX : 0; cg = (cci & 2) ? CMAX : 0; cb = (cci & 4) ? CMAX : 0;
            end
            2: begin
              ck = cx * 8 / HA;
              cr = (ck & 1) ? CMAX : 0; cg = (ck & 2) ? CMAX : 0; cb = (ck & 4) ? CMAX : 0;
            end
            3: begin
              cr = (((cx >> CL) ^ (cy >> CL)) & 1) ? CMAX : 0; cg = cr; cb = cr;
            end
            4: begin
              cr = ((cx >> GS) > CMAX) ? CMAX : (cx >> GS);
              cg = ((cy >> GS) > CMAX) ? CMAX : (cy >> GS);
              cb = CMAX - cr;
            end
            default: begin cr = CMAX; cg = CMAX; cb = CMAX; end
          endcase
        end
        exp_v = {e_hs, e_vs, e_on, e_fs, 4'(cr), 4'(cg), 4'(cb)};
      end
      act_v = {h_sync, v_sync, onscreen, frame_start, R, G, B};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model n=%0d: got {hs,vs,on,fs,rgb}=%h, expected %h", n, act_v, exp_v);
      end
    end
  end

  task automatic wait_pixel(input int x, input int y);
    int p;
    bit found;
    found = 0;
    for (int i = 0; i < 2 * FT + 8; i++) begin
      @(negedge clk);
      if (n >= 1) begin
        p = (n - 1) % FT;
        if (p % HT == x && p / HT == y) begin
          found = 1;
          break;
        end
      end
    end
    if (!found) check($sformatf("wait_pixel(%0d,%0d) timeout", x, y), 0, 1);
  endtask

  task automatic check_rgb(input string name, input int r, input int g, input int b);
    check({name, " R"}, int'(R), r);
    check({name, " G"}, int'(G), g);
    check({name, " B"}, int'(B), b);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " h_sync"}, int'(h_sync), 1);
    check({name, " v_sync"}, int'(v_sync), 1);
    check({name, " onscreen"}, int'(onscreen), 0);
    check({name, " frame_start"}, int'(frame_start), 0);
    check_rgb(name, 0, 0, 0);
  endtask

  int exp_ci [17] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 0, 0};
  int on_cnt, hs_f0, hs_f1, hs_w, vs_f0, vs_f1, vs_w, ci;
  logic hs_prev, vs_prev;

  initial begin
    // Reset state and release.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first frame_start", int'(frame_start), 1);
    check("first onscreen", int'(onscreen), 1);
    check_rgb("first pixel white", 15, 15, 15);

    // Sync timing over two frames.
    on_cnt = 0; hs_f0 = -1; hs_f1 = -1; hs_w = 0; vs_f0 = -1; vs_f1 = -1; vs_w = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (onscreen) on_cnt++;
      if (hs_prev && !h_sync) begin
        if (hs_f0 < 0) hs_f0 = i; else if (hs_f1 < 0) hs_f1 = i;
      end
      if (!h_sync && hs_f0 >= 0 && hs_f1 < 0) hs_w++;
      if (vs_prev && !v_sync) begin
        if (vs_f0 < 0) vs_f0 = i; else if (vs_f1 < 0) vs_f1 = i;
      end
      if (!v_sync && vs_f0 >= 0 && vs_f1 < 0) vs_w++;
      hs_prev = h_sync;
      vs_prev = v_sync;
    end
    check("onscreen cycles in 2 frames", on_cnt, 2400);
    check("h_sync first fall at h_cnt 44", hs_f0, 43);
    check("h_sync period", hs_f1 - hs_f0, 52);
    check("h_sync low width", hs_w, 6);
    check("v_sync first fall at v_cnt 32", vs_f0, 1663);
    check("v_sync period", vs_f1 - vs_f0, 1924);
    check("v_sync low width", vs_w, 156);

    // Asynchronous reset mid-frame, then colour cycling from a clean start.
    wait_pixel(30, 20);
    check("pre-reset onscreen", int'(onscreen), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    sw = 3'd1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post-reset frame_start", int'(frame_start), 1);
    wait_pixel(5, 5);
    check_rgb("cycle frame0 white", 15, 15, 15);
    for (int j = 0; j < 17; j++) begin
      wait_pixel(5, 5);
      ci = exp_ci[j];
      check_rgb($sformatf("cycle frame%0d", j + 1),
                (ci & 1) ? 15 : 0, (ci & 2) ? 15 : 0, (ci & 4) ? 15 : 0);
    end

    // Mid-frame switch to checker must wait for the frame end.
    sw = 3'd0;
    wait_pixel(0, 0);
    wait_pixel(0, 15);
    sw = 3'd3;
    wait_pixel(10, 20);
    check_rgb("after mid-frame sw still white", 15, 15, 15);
    wait_pixel(0, 0);
    check_rgb("checker (0,0)", 0, 0, 0);
    wait_pixel(4, 0);
    check_rgb("checker (4,0)", 15, 15, 15);
    wait_pixel(4, 4);
    check_rgb("checker (4,4)", 0, 0, 0);

    // Gradient with saturation.
    sw = 3'd4;
    wait_pixel(0, 0);
    check_rgb("gradient (0,0)", 0, 0, 15);
    wait_pixel(45, 3);
    check_rgb("gradient porch (45,3)", 0, 0, 0);
    wait_pixel(10, 6);
    check_rgb("gradient (10,6)", 5, 3, 10);
    wait_pixel(39, 29);
    check_rgb("gradient (39,29)", 15, 14, 0);
    wait_pixel(5, 33);
    check_rgb("gradient porch (5,33)", 0, 0, 0);

    // Colour bars: bar width is 5 pixels here.
    sw = 3'd2;
    wait_pixel(4, 0);
    check_rgb("bars (4,0)", 0, 0, 0);
    wait_pixel(5, 0);
    check_rgb("bars (5,0)", 15, 0, 0);
    wait_pixel(20, 0);
    check_rgb("bars (20,0)", 0, 0, 15);
    wait_pixel(39, 0);
    check_rgb("bars (39,0)", 15, 15, 15);

    // Modes 6 and 5 fall back to white.
    sw = 3'd6;
    wait_pixel(0, 0);
    check_rgb("mode6 (0,0)", 15, 15, 15);
    wait_pixel(17, 11);
    check_rgb("mode6 (17,11)", 15, 15, 15);
    sw = 3'd5;
    wait_pixel(0, 0);
    wait_pixel(20, 20);
    check_rgb("mode5 (20,20)", 15, 15, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter COLOR_W, default 4: bits per colour channel.
REQ-006 Parameter FRAMES_PER_STEP, default 60: frames per colour-index step; legal range 1..65535.
REQ-007 Parameter CELL_LOG2, default 5: checkerboard cell size is 2^CELL_LOG2 pixels.
REQ-008 Parameter GRAD_SHIFT, default 5: right-shift applied to the counters in gradient mode.
REQ-009 clk  input  1  pixel clock (25 MHz); all logic rises on posedge clk.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 sw  input  3  mode select, asynchronous to clk.
REQ-012 h_sync  output  1  horizontal sync, active-low.
REQ-013 v_sync  output  1  vertical sync, active-low.
REQ-014 onscreen  output  1  high while in the active area.
REQ-015 R, G, B  output  COLOR_W each  pixel colour channels.
REQ-016 frame_start  output  1  one-cycle pulse aligned with the first active pixel of each frame.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters); v_cnt SHALL increment when h_cnt wraps and SHALL run 0..V_TOTAL-1.
REQ-018 Active area SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-019 Sync low intervals SHALL be h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-020 All outputs SHALL be registered with exactly 1 clk latency from counter state, so sync, onscreen and colour remain mutually aligned.
REQ-021 sw SHALL pass through a 2-flop synchroniser; the active mode SHALL update only at the frame-end cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1). A mid-frame sw change SHALL NOT affect the current frame.
REQ-022 frame_cnt (16 bit) SHALL increment at each frame end; on reaching FRAMES_PER_STEP-1 it SHALL wrap to 0 in the same cycle that the 3-bit color_idx increments (7 wraps to 0).
REQ-023 Mode 0, white: R=G=B=all ones.
REQ-024 Mode 1, cycling: each of R/G/B SHALL be all ones if color_idx bit 0/1/2 respectively is set, else zero.
REQ-025 Mode 2, bars: bar k = h_cnt*8/H_ACTIVE (0..7), coloured per the REQ-024 rule using k in place of color_idx.
REQ-026 Mode 3, checker: all ones if bit 0 of ((h_cnt>>CELL_LOG2) XOR (v_cnt>>CELL_LOG2)) is 1, else zero.
REQ-027 Mode 4, gradient: R=min(h_cnt>>GRAD_SHIFT, 2^COLOR_W-1), G=min(v_cnt>>GRAD_SHIFT, 2^COLOR_W-1), B=~R; saturating arithmetic, no wrap.
REQ-028 Modes 5-7 SHALL behave as mode 0.
REQ-029 Outside the active area, R=G=B=0 in every mode.
REQ-030 frame_start SHALL be high for exactly one cycle per frame, coincident with the output of pixel (0,0).

Reset
REQ-031 While rst_n=0: h_cnt=v_cnt=0, frame_cnt=0, color_idx=0, mode=0, synchroniser=0, h_sync=v_sync=1, onscreen=0, R=G=B=0, frame_start=0.
REQ-032 Reset assertion mid-frame SHALL take effect immediately (asynchronous); after deassertion the first output cycle SHALL be pixel (0,0) with frame_start=1.

Verification
REQ-033 Reset release, default parameters -> h_sync period 800 clk with low width 96 starting at h_cnt 656; v_sync period 420000 clk with low width 1600; 307200 onscreen cycles per frame.
REQ-034 sw=1, FRAMES_PER_STEP=2 -> solid colour steps black, R, G, RG, B, RB, GB, white every 2 frames, then wraps back to black.
REQ-035 sw changes 0->3 at v_cnt=100 -> rest of that frame stays white; next frame is checker: pixel (0,0) black, pixel (32,0) all ones, pixel (32,32) black.
REQ-036 sw=4, COLOR_W=4 -> pixel (0,0) gives R=0,G=0,B=15; pixel (639,479) gives R=15,G=14,B=0; porch pixels give R=G=B=0.
REQ-037 sw=2 -> pixel (79,0)=black, pixel (80,0)=R only, pixel (639,0)=white; sw=6 -> every active pixel white.
REQ-038 rst_n pulsed low at pixel (300,200) -> all outputs go to reset values without waiting for a clk edge; after release, frame_start pulses on the first cycle and color_idx=0.
